axi_burst_sequencer: RTL and testbench
======================================

// Module: axi_burst_sequencer
// PURPOSE
//  Splits one transfer descriptor (start address, total beats, direction) into legal AXI bursts and sequences
//  the AXI master engine (go/RNW/address/burst_length/burst_size/increment_burst; busy/done/error) burst by burst.
//  Sits between the JTAG-visible control register and the AXI master, replacing manual per-burst go pokes.
//  Bursts never cross a 4 KB boundary, never exceed MAX_BEATS, and stop on the first engine error.
// PARAMETERS
//  ADDR_WIDTH     32    byte address width
//  DATA_WIDTH     64    AXI data width; bytes/beat BPB = DATA_WIDTH/8 (power of 2, 8..1024)
//  CNT_WIDTH      16    width of total-beat count in a descriptor
//  MAX_BEATS      256   max beats per burst (1..256)
//  TIMEOUT_CYC    65535 cycles allowed per burst (go-to-done) before timeout error
// PORTS
//  clk              in   1           single clock
//  rst              in   1           synchronous, active-high reset
//  cmd_valid        in   1           descriptor valid
//  cmd_ready        out  1           high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_rnw          in   1           1 = read, 0 = write
//  cmd_addr         in   ADDR_WIDTH  start byte address, must be BPB-aligned
//  cmd_beats        in   CNT_WIDTH   total beats; 0 legal (no-op)
//  cmd_abort        in   1           request early stop (level, sampled each cycle)
//  mst_go           out  1           start request to engine
//  mst_rnw          out  1           direction for current burst
//  mst_address      out  ADDR_WIDTH  burst start address
//  mst_burst_length out  8           beats in burst, 1..256 (256 encoded as 8'd0)
//  mst_burst_size   out  7           bytes per beat, constant BPB (64 and up encoded as BPB mod 128)
//  mst_increment    out  1           constant 1 (INCR bursts)
//  mst_busy         in   1           engine busy
//  mst_done         in   1           engine burst complete (single-cycle pulse)
//  mst_error        in   1           engine response error, valid with mst_done
//  seq_busy         out  1           descriptor in progress
//  seq_done         out  1           one-cycle pulse at descriptor completion (success or failure)
//  seq_error        out  2           00 ok, 01 engine error, 10 timeout, 11 misaligned/aborted; sticky until next accept
//  beats_left       out  CNT_WIDTH   beats not yet issued
//  bursts_issued    out  16          bursts completed in current descriptor (saturates at 16'hFFFF)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cmd_ready=1, mst_increment=1, mst_burst_size=BPB. Takes effect next edge, even mid-burst.
//  FSM IDLE -> CALC -> ISSUE -> WAIT -> (CALC | FINISH) -> IDLE.
//  IDLE: on accept, latch rnw/addr/beats, clear counters and seq_error.
//    - cmd_addr not BPB-aligned: go directly to FINISH with seq_error=11, no burst.
//    - cmd_beats==0: go to FINISH with seq_error=00.
//  CALC (1 cycle): n = min(beats_left, MAX_BEATS, (4096 - addr[11:0]) / BPB); register n, mst_address, mst_burst_length.
//  ISSUE: assert mst_go; hold until mst_busy==1, then drop go and enter WAIT.
//    - cmd_abort before busy seen: drop go, go to FINISH with 11.
//  WAIT: count cycles; on mst_done, bursts_issued+1, addr += n*BPB, beats_left -= n.
//    - mst_error set: go to FINISH with 01.
//    - beats_left==0: go to FINISH with 00.
//    - cmd_abort seen during ISSUE/WAIT (latched): go to FINISH with 11 only after done. Never abandon a burst on the bus.
//    - else: go to CALC.
//    - Timeout counter reaching TIMEOUT_CYC (counted from ISSUE entry): go to FINISH with 10. Engine recovery is software's job (aresetn).
//  FINISH (1 cycle): seq_done=1, seq_busy drops next cycle.
//  seq_busy=1 in every state except IDLE.
//  Latency: accept -> mst_go = 2 cycles; done -> next mst_go = 2 cycles.
//  Address arithmetic is modulo 2^ADDR_WIDTH; 4 KB split keeps wrap inside a page.
//  mst_done outside WAIT is ignored.
// STRUCTURE
//  Shared package axi_seq_pkg: seq_state_e enum, seq_err_e codes, AXI_4K_BOUNDARY=4096.
//  Sub-module axi_burst_calc (combinational min/boundary computation, registered in CALC).
//  Everything else lives in this file.
// TESTING
//  1. addr=0x1000, beats=512, write, MAX_BEATS=256 -> 2 bursts: (0x1000,len 256), (0x1800,len 256); seq_error=00; bursts_issued=2.
//  2. addr=0x0FF0, beats=10, read -> bursts (0x0FF0,len 2), (0x1000,len 8); no burst crosses 0x1000.
//  3. beats=0 -> seq_done 2 cycles after accept, mst_go never asserted. addr=0x1004 -> seq_error=11, no go.
//  4. Engine returns mst_error on 2nd of 3 bursts -> seq_error=01, bursts_issued=2, 3rd burst never issued.
//  5. cmd_abort pulsed mid-WAIT -> current burst finishes, no further go; seq_error=11.
//     Engine never sets busy -> seq_error=10 after TIMEOUT_CYC.
//  6. rst asserted in WAIT -> next cycle mst_go=0, seq_busy=0, cmd_ready=1; new descriptor accepted afterwards.

Source files
------------

// File: rtl/axi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_seq_pkg
// Description : Shared state/error encodings and constants for the AXI burst
//               sequencer and its burst-size calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_seq_pkg;

    localparam int AXI_4K_BOUNDARY = 4096;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_ENGINE  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ABORT   = 2'b11
    } seq_err_e;

endpackage
`default_nettype wire

// File: rtl/axi_burst_calc.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_calc
// Description : Combinational burst size: min(beats left, MAX_BEATS, beats to
//               the next 4 KB page boundary).
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_calc
    import axi_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_BEATS  = 256
) (
    input  logic [11:0]          i_page_offset,
    input  logic [CNT_WIDTH-1:0] i_beats_left,
    output logic [8:0]           o_beats
);

    localparam int c_BPB   = DATA_WIDTH / 8;
    localparam int c_OFF_W = $clog2(c_BPB);
    localparam int c_W     = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

    logic [12:0]    w_page_bytes;
    logic [12:0]    w_page_beats;
    logic [c_W-1:0] w_left;
    logic [c_W-1:0] w_max;
    logic [c_W-1:0] w_page;
    logic [c_W-1:0] w_min;

    always_comb begin
        // Offset is beat-aligned, so the shift is an exact division.
        w_page_bytes = 13'(AXI_4K_BOUNDARY) - {1'b0, i_page_offset};
        w_page_beats = w_page_bytes >> c_OFF_W;
        w_left       = c_W'(i_beats_left);
        w_max        = c_W'(MAX_BEATS);
        w_page       = c_W'(w_page_beats);
        w_min        = w_left;
        if (w_max < w_min) begin
            w_min = w_max;
        end
        if (w_page < w_min) begin
            w_min = w_page;
        end
        o_beats = w_min[8:0];
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_sequencer
// Description : Splits a transfer descriptor into 4 KB-safe AXI INCR bursts and
//               drives the AXI master engine one burst at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_sequencer
    import axi_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int CNT_WIDTH   = 16,
    parameter int MAX_BEATS   = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_beats,
    input  logic                  cmd_abort,
    output logic                  mst_go,
    output logic                  mst_rnw,
    output logic [ADDR_WIDTH-1:0] mst_address,
    output logic [7:0]            mst_burst_length,
    output logic [6:0]            mst_burst_size,
    output logic                  mst_increment,
    input  logic                  mst_busy,
    input  logic                  mst_done,
    input  logic                  mst_error,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic [1:0]            seq_error,
    output logic [CNT_WIDTH-1:0]  beats_left,
    output logic [15:0]           bursts_issued
);

    localparam int           c_BPB        = DATA_WIDTH / 8;
    localparam int           c_OFF_W      = $clog2(c_BPB);
    localparam int           c_TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [6:0]   c_BURST_SIZE = 7'(c_BPB % 128);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);

    seq_state_e              r_state_q,  w_state_d;
    seq_err_e                r_err_q,    w_err_d;
    logic                    r_rnw_q,    w_rnw_d;
    logic                    r_abort_q,  w_abort_d;
    logic [ADDR_WIDTH-1:0]   r_addr_q,   w_addr_d;
    logic [ADDR_WIDTH-1:0]   r_maddr_q,  w_maddr_d;
    logic [7:0]              r_len_q,    w_len_d;
    logic [8:0]              r_n_q,      w_n_d;
    logic [CNT_WIDTH-1:0]    r_beats_q,  w_beats_d;
    logic [15:0]             r_bursts_q, w_bursts_d;
    logic [c_TMR_W-1:0]      r_timer_q,  w_timer_d;

    logic [8:0]              w_calc_n;
    logic [CNT_WIDTH-1:0]    w_beats_after;
    logic                    w_misaligned;
    logic                    w_abort_seen;

    axi_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .MAX_BEATS  (MAX_BEATS)
    ) u_calc (
        .i_page_offset (r_addr_q[11:0]),
        .i_beats_left  (r_beats_q),
        .o_beats       (w_calc_n)
    );

    assign w_misaligned  = |cmd_addr[c_OFF_W-1:0];
    assign w_beats_after = r_beats_q - CNT_WIDTH'(r_n_q);
    assign w_abort_seen  = r_abort_q | cmd_abort;

    always_comb begin
        w_state_d  = r_state_q;
        w_err_d    = r_err_q;
        w_rnw_d    = r_rnw_q;
        w_abort_d  = r_abort_q;
        w_addr_d   = r_addr_q;
        w_maddr_d  = r_maddr_q;
        w_len_d    = r_len_q;
        w_n_d      = r_n_q;
        w_beats_d  = r_beats_q;
        w_bursts_d = r_bursts_q;
        w_timer_d  = r_timer_q;

        case (r_state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_rnw_d    = cmd_rnw;
                    w_addr_d   = cmd_addr;
                    w_beats_d  = cmd_beats;
                    w_bursts_d = 16'd0;
                    w_abort_d  = 1'b0;
                    if (w_misaligned) begin
                        w_err_d   = ERR_ABORT;
                        w_state_d = ST_FINISH;
                    end else begin
                        w_err_d   = ERR_OK;
                        w_state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // A zero-beat descriptor falls out here, giving it the same
                // two-cycle accept-to-response latency as a real burst.
                if (r_beats_q == '0) begin
                    w_state_d = ST_FINISH;
                end else begin
                    w_n_d     = w_calc_n;
                    w_maddr_d = r_addr_q;
                    w_len_d   = w_calc_n[7:0];
                    w_timer_d = '0;
                    w_state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_timer_q == c_TMR_LAST) begin
                    w_err_d   = ERR_TIMEOUT;
                    w_state_d = ST_FINISH;
                end else if (mst_busy) begin
                    w_abort_d = w_abort_seen;
                    w_timer_d = r_timer_q + 1'b1;
                    w_state_d = ST_WAIT;
                end else if (cmd_abort) begin
                    w_err_d   = ERR_ABORT;
                    w_state_d = ST_FINISH;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            ST_WAIT: begin
                w_abort_d = w_abort_seen;
                if (mst_done) begin
                    w_bursts_d = (r_bursts_q == 16'hFFFF) ? r_bursts_q : r_bursts_q + 16'd1;
                    w_addr_d   = r_addr_q + (ADDR_WIDTH'(r_n_q) << c_OFF_W);
                    w_beats_d  = w_beats_after;
                    if (mst_error) begin
                        w_err_d   = ERR_ENGINE;
                        w_state_d = ST_FINISH;
                    end else if (w_beats_after == '0) begin
                        w_state_d = ST_FINISH;
                    end else if (w_abort_seen) begin
                        w_err_d   = ERR_ABORT;
                        w_state_d = ST_FINISH;
                    end else begin
                        w_state_d = ST_CALC;
                    end
                end else if (r_timer_q == c_TMR_LAST) begin
                    w_err_d   = ERR_TIMEOUT;
                    w_state_d = ST_FINISH;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_err_q    <= ERR_OK;
            r_rnw_q    <= 1'b0;
            r_abort_q  <= 1'b0;
            r_addr_q   <= '0;
            r_maddr_q  <= '0;
            r_len_q    <= '0;
            r_n_q      <= '0;
            r_beats_q  <= '0;
            r_bursts_q <= '0;
            r_timer_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_err_q    <= w_err_d;
            r_rnw_q    <= w_rnw_d;
            r_abort_q  <= w_abort_d;
            r_addr_q   <= w_addr_d;
            r_maddr_q  <= w_maddr_d;
            r_len_q    <= w_len_d;
            r_n_q      <= w_n_d;
            r_beats_q  <= w_beats_d;
            r_bursts_q <= w_bursts_d;
            r_timer_q  <= w_timer_d;
        end
    end

    assign cmd_ready        = (r_state_q == ST_IDLE);
    assign seq_busy         = (r_state_q != ST_IDLE);
    assign seq_done         = (r_state_q == ST_FINISH);
    assign mst_go           = (r_state_q == ST_ISSUE);
    assign mst_rnw          = r_rnw_q;
    assign mst_address      = r_maddr_q;
    assign mst_burst_length = r_len_q;
    assign mst_burst_size   = c_BURST_SIZE;
    assign mst_increment    = 1'b1;
    assign seq_error        = r_err_q;
    assign beats_left       = r_beats_q;
    assign bursts_issued    = r_bursts_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_sequencer
// Description : Scoreboard bench: directed descriptors push expected bursts and
//               completions; an engine model/monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_sequencer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int MB = 256;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rnw, cmd_abort;
    logic [AW-1:0] cmd_addr;
    logic [CW-1:0] cmd_beats;
    logic          mst_go, mst_rnw, mst_increment;
    logic [AW-1:0] mst_address;
    logic [7:0]    mst_burst_length;
    logic [6:0]    mst_burst_size;
    logic          mst_busy, mst_done, mst_error;
    logic          seq_busy, seq_done;
    logic [1:0]    seq_error;
    logic [CW-1:0] beats_left;
    logic [15:0]   bursts_issued;

    always #5 clk = ~clk;

    axi_burst_sequencer #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .CNT_WIDTH (CW),
        .MAX_BEATS (MB), .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk), .rst (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rnw (cmd_rnw),
        .cmd_addr (cmd_addr), .cmd_beats (cmd_beats), .cmd_abort (cmd_abort),
        .mst_go (mst_go), .mst_rnw (mst_rnw), .mst_address (mst_address),
        .mst_burst_length (mst_burst_length), .mst_burst_size (mst_burst_size),
        .mst_increment (mst_increment), .mst_busy (mst_busy), .mst_done (mst_done),
        .mst_error (mst_error), .seq_busy (seq_busy), .seq_done (seq_done),
        .seq_error (seq_error), .beats_left (beats_left), .bursts_issued (bursts_issued)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic        rnw;
    } burst_t;

    typedef struct {
        logic [1:0]  err;
        logic [15:0] bursts;
        logic [15:0] left;
        int          lat;
    } done_t;

    burst_t exp_bursts[$];
    done_t  exp_done[$];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   eng_lat = 2;
    int   err_on_burst = 0;
    logic eng_dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Engine model and output monitor: samples on the falling edge.
    initial begin : engine
        logic   active;
        int     cnt;
        int     nburst;
        int     acc_cyc;
        int     last_done;
        burst_t b;
        done_t  d;
        active = 1'b0; cnt = 0; nburst = 0; acc_cyc = 0; last_done = -1;
        mst_busy = 1'b0; mst_done = 1'b0; mst_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0; mst_busy = 1'b0; mst_done = 1'b0; mst_error = 1'b0;
                continue;
            end
            if (cmd_valid && cmd_ready) begin
                acc_cyc = cyc; nburst = 0; last_done = -1;
            end
            if (seq_done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_seq_done", 1, 0);
                end else begin
                    d = exp_done.pop_front();
                    chk("seq_error", seq_error, d.err);
                    chk("bursts_issued", bursts_issued, d.bursts);
                    chk("beats_left", beats_left, d.left);
                    if (d.lat >= 0) chk("done_latency", cyc - acc_cyc, d.lat);
                end
                done_cnt++;
            end
            mst_done = 1'b0;
            mst_error = 1'b0;
            if (active) begin
                if (cnt == 0) begin
                    mst_done = 1'b1;
                    mst_error = (nburst == err_on_burst);
                    mst_busy = 1'b0;
                    active = 1'b0;
                    last_done = cyc;
                end else begin
                    cnt--;
                end
            end else if (mst_go && !eng_dead) begin
                nburst++;
                if (last_done < 0) chk("go_after_accept", cyc - acc_cyc, 2);
                else               chk("go_after_done", cyc - last_done, 2);
                if (exp_bursts.size() == 0) begin
                    chk("unexpected_burst_addr", mst_address, 0);
                    chk("unexpected_burst", 1, 0);
                end else begin
                    b = exp_bursts.pop_front();
                    chk("burst_addr", mst_address, b.addr);
                    chk("burst_len", mst_burst_length, b.len);
                    chk("burst_rnw", mst_rnw, b.rnw);
                end
                mst_busy = 1'b1;
                active = 1'b1;
                cnt = eng_lat;
            end
        end
    end

    task automatic push_burst(input logic [31:0] a, input logic [7:0] l, input logic r);
        burst_t b;
        b.addr = a; b.len = l; b.rnw = r;
        exp_bursts.push_back(b);
    endtask

    task automatic push_done(input logic [1:0] e, input int nb, input int left, input int lat);
        done_t d;
        d.err = e; d.bursts = 16'(nb); d.left = 16'(left); d.lat = lat;
        exp_done.push_back(d);
    endtask

    task automatic send_cmd(input logic r, input logic [31:0] a, input int beats);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_rnw = r; cmd_addr = a; cmd_beats = CW'(beats);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int i;
        i = 0;
        while (done_cnt <= target && i < 3000) begin
            @(posedge clk);
            i++;
        end
        n_checks++;
        if (done_cnt <= target) begin
            n_fail++;
            $display("FAIL seq_done_wait: got no completion within %0d cycles", i);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input logic r, input logic [31:0] a, input int beats);
        int t;
        t = done_cnt;
        send_cmd(r, a, beats);
        wait_done(t);
    endtask

    task automatic wait_busy();
        int i;
        i = 0;
        while (!mst_busy && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("engine_busy_seen", mst_busy, 1);
    endtask

    initial begin : main
        rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0;
        cmd_beats = '0; cmd_abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_mst_go", mst_go, 0);
        chk("rst_seq_busy", seq_busy, 0);
        chk("rst_seq_done", seq_done, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_burst_size", mst_burst_size, 8);
        chk("rst_increment", mst_increment, 1);
        chk("rst_burst_length", mst_burst_length, 0);
        chk("rst_address", mst_address, 0);
        chk("rst_beats_left", beats_left, 0);
        chk("rst_bursts_issued", bursts_issued, 0);

        // Two full 256-beat write bursts.
        push_burst(32'h1000, 8'd0, 1'b0);
        push_burst(32'h1800, 8'd0, 1'b0);
        push_done(2'b00, 2, 0, -1);
        run(1'b0, 32'h1000, 512);

        // Read straddling a 4 KB page: split at 0x1000.
        push_burst(32'h0FF0, 8'd2, 1'b1);
        push_burst(32'h1000, 8'd8, 1'b1);
        push_done(2'b00, 2, 0, -1);
        run(1'b1, 32'h0FF0, 10);

        // Zero beats and misaligned start: no bursts.
        push_done(2'b00, 0, 0, 2);
        run(1'b0, 32'h2000, 0);
        push_done(2'b11, 0, 4, 1);
        run(1'b0, 32'h1004, 4);

        // Engine error on the second of three bursts.
        err_on_burst = 2;
        push_burst(32'h2000, 8'd0, 1'b0);
        push_burst(32'h2800, 8'd0, 1'b0);
        push_done(2'b01, 2, 88, -1);
        run(1'b0, 32'h2000, 600);
        err_on_burst = 0;

        // Abort pulsed while the first burst is on the bus.
        begin
            int t;
            t = done_cnt;
            eng_lat = 6;
            push_burst(32'h0000, 8'd0, 1'b1);
            push_done(2'b11, 1, 344, -1);
            send_cmd(1'b1, 32'h0000, 600);
            wait_busy();
            @(posedge clk); #1 cmd_abort = 1'b1;
            @(posedge clk); #1 cmd_abort = 1'b0;
            wait_done(t);
            eng_lat = 2;
        end

        // Engine never goes busy: timeout.
        eng_dead = 1'b1;
        push_done(2'b10, 0, 40, -1);
        run(1'b0, 32'h5000, 40);
        eng_dead = 1'b0;

        // Reset in the middle of a burst, then a fresh descriptor.
        eng_lat = 20;
        push_burst(32'h0000, 8'd16, 1'b0);
        send_cmd(1'b0, 32'h0000, 16);
        wait_busy();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_mst_go", mst_go, 0);
        chk("midrst_seq_busy", seq_busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        eng_lat = 1;
        push_burst(32'h3F00, 8'd32, 1'b0);
        push_burst(32'h4000, 8'd8, 1'b0);
        push_done(2'b00, 2, 0, -1);
        run(1'b0, 32'h3F00, 40);

        chk("exp_bursts_drained", exp_bursts.size(), 0);
        chk("exp_done_drained", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
